// File: rtl/gemm_output_collector_pkg.sv
// gemm_output_collector_pkg: shared types and defaults for the GEMM output collector
package gemm_output_collector_pkg;
  typedef enum logic {COLL_IDLE, COLL_ACCUM} collector_state_t;
  localparam int DEFAULT_ACC_WIDTH = 16;
  localparam int DEFAULT_COLL_FIFO_DEPTH = 4;
endpackage

// File: rtl/gemm_output_collector_if.sv
// gemm_output_collector_if: GEMM beat stream in, collected vector stream out
interface gemm_output_collector_if
  import gemm_output_collector_pkg::*;
#(
  parameter int SA_SIZE = 8,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_COLL_FIFO_DEPTH,
  parameter int TILE_CNT_WIDTH = 4
);
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_vec;
  logic in_valid;
  logic [TILE_CNT_WIDTH-1:0] num_tiles;
  logic clear;
  logic [SA_SIZE-1:0][ACC_WIDTH-1:0] out_vec;
  logic out_valid;
  logic out_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic overflow;
  logic busy;
  modport master (
    output in_vec, in_valid, num_tiles, clear, out_ready,
    input out_vec, out_valid, fifo_count, overflow, busy
  );
  modport slave (
    input in_vec, in_valid, num_tiles, clear, out_ready,
    output out_vec, out_valid, fifo_count, overflow, busy
  );
endinterface

// File: rtl/gemm_collector_fifo.sv
// gemm_collector_fifo: vector-wide first-word-fall-through FIFO, head reads 0 when empty
module gemm_collector_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  // a push into a full FIFO is only accepted when the head leaves in the same cycle
  always_comb begin
    empty = count == '0;
    full = count == CW'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rd];
  end
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) {wr, rd, count} <= '0;
    else if (clear) {wr, rd, count} <= '0;
    else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset: empty forces the head to 0
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr] <= din;
endmodule

// File: rtl/gemm_output_collector.sv
// gemm_output_collector: sums num_tiles GEMM output vectors and queues each sum in a FWFT FIFO
module gemm_output_collector
  import gemm_output_collector_pkg::*;
#(
  parameter int SA_SIZE = 8,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_COLL_FIFO_DEPTH,
  parameter int TILE_CNT_WIDTH = 4
) (
  input logic clk,
  input logic reset,
  gemm_output_collector_if.slave bus
);
  typedef logic [SA_SIZE-1:0][ACC_WIDTH-1:0] vec_t;
  collector_state_t state, state_nx;
  vec_t acc, sum, in_ext;
  logic [TILE_CNT_WIDTH-1:0] tile_cnt, tiles_lat, nt;
  logic push_q, full, empty, pop, last;
  // zero-extend the incoming beat and form the wrapping running sum
  always_comb begin
    in_ext = '0;
    sum = '0;
    for (int i = 0; i < SA_SIZE; i++) begin
      in_ext[i] = ACC_WIDTH'(bus.in_vec[i][WEIGHT_ACTIVATION_SIZE-1:0]);
      sum[i] = acc[i] + in_ext[i];
    end
    nt = bus.num_tiles == '0 ? TILE_CNT_WIDTH'(1) : bus.num_tiles;
    last = state == COLL_IDLE ? nt == TILE_CNT_WIDTH'(1) : tile_cnt == tiles_lat - TILE_CNT_WIDTH'(1);
    pop = !empty && bus.out_ready;
  end
  // state register; clear behaves like a synchronous reset
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= COLL_IDLE;
    else state <= bus.clear ? COLL_IDLE : state_nx;
  // next state: only beats move the FSM, idle cycles hold it
  always_comb state_nx = bus.in_valid ? (last ? COLL_IDLE : COLL_ACCUM) : state;
  // FSM outputs
  always_comb begin
    bus.busy = state == COLL_ACCUM;
    bus.out_valid = !empty;
  end
  // acc doubles as the push data register: the completed sum lands in it one cycle before the FIFO write
  always_ff @(posedge clk or posedge reset)
    if (reset) {acc, tile_cnt, tiles_lat, push_q} <= '0;
    else if (bus.clear) {acc, tile_cnt, tiles_lat, push_q} <= '0;
    else begin
      push_q <= bus.in_valid && last;
      if (bus.in_valid) begin
        acc <= state == COLL_IDLE ? in_ext : sum;
        tile_cnt <= last ? '0 : tile_cnt + TILE_CNT_WIDTH'(1);
        if (state == COLL_IDLE) tiles_lat <= nt;
      end
    end
  // sticky flag for a completed group lost to a full FIFO
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.overflow <= 1'b0;
    else if (bus.clear) bus.overflow <= 1'b0;
    else if (push_q && full && !pop) bus.overflow <= 1'b1;
  gemm_collector_fifo #(
    .WIDTH(SA_SIZE * ACC_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(bus.clear),
    .push(push_q),
    .pop(pop),
    .din(acc),
    .dout(bus.out_vec),
    .full(full),
    .empty(empty),
    .count(bus.fifo_count)
  );
endmodule

// File: tb/tb_gemm_output_collector.sv
// tb_gemm_output_collector: directed scenario tests for the GEMM output collector
module tb_gemm_output_collector;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  gemm_output_collector_if #(
    .SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .ACC_WIDTH(8), .FIFO_DEPTH(4), .TILE_CNT_WIDTH(4)
  ) bus ();
  gemm_output_collector #(
    .SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .ACC_WIDTH(8), .FIFO_DEPTH(4), .TILE_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] nt);
    bus.in_vec[0] = a;
    bus.in_vec[1] = b;
    bus.num_tiles = nt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_vec = '0;
    bus.in_valid = 1'b0;
    bus.num_tiles = 4'd1;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.fifo_count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b want=0", bus.overflow); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
    total++; if (bus.out_vec !== 16'h0000) begin bad++; $display("FAIL rst_vec got=%h want=0000", bus.out_vec); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    send(8'd6, 8'd10, 4'd1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat got=%0b want=0", bus.out_valid); end
    send(8'd9, 8'd4, 4'd1);
    total++; if (bus.out_vec !== 16'h0a06 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_first got=%h/%0b want=0a06/1", bus.out_vec, bus.out_valid); end
    tick();
    total++; if (bus.out_vec !== 16'h0409 || bus.fifo_count !== 3'd1) begin bad++; $display("FAIL single_second got=%h/%0d want=0409/1", bus.out_vec, bus.fifo_count); end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b/%0b want=0/0", bus.out_valid, bus.overflow); end
  endtask

  task automatic test_tiles();
    bus.out_ready = 1'b1;
    send(8'd1, 8'd2, 4'd3);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL tiles_busy1 got=%0b want=1", bus.busy); end
    tick();
    send(8'd3, 8'd4, 4'd1);
    tick();
    total++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL tiles_busy2 got=%0b/%0b want=1/0", bus.busy, bus.out_valid); end
    send(8'd5, 8'd6, 4'd3);
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL tiles_end got=%0b/%0b want=0/0", bus.busy, bus.out_valid); end
    tick();
    total++; if (bus.out_vec !== 16'h0c09 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL tiles_sum got=%h/%0b want=0c09/1", bus.out_vec, bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL tiles_single got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    send(8'd200, 8'd255, 4'd2);
    send(8'd100, 8'd1, 4'd2);
    tick();
    total++; if (bus.out_vec !== 16'h002c) begin bad++; $display("FAIL wrap_sum got=%h want=002c", bus.out_vec); end
    tick();
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(8'(k), 8'(k), 4'd1);
    tick();
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", bus.fifo_count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", bus.overflow); end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus.out_vec !== {8'(k), 8'(k)}) begin bad++; $display("FAIL ovf_drain%0d got=%h want=%h", k, bus.out_vec, {8'(k), 8'(k)}); end
      tick();
    end
    total++; if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_end got=%0b/%0b want=0/1", bus.out_valid, bus.overflow); end
  endtask

  task automatic test_push_pop_full();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0b want=0", bus.overflow); end
    bus.out_ready = 1'b0;
    for (int k = 10; k <= 14; k++) send(8'(k), 8'(k), 4'd1);
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL pp_full got=%0d want=4", bus.fifo_count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b0) begin bad++; $display("FAIL pp_count got=%0d/%0b want=4/0", bus.fifo_count, bus.overflow); end
    bus.out_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      total++; if (bus.out_vec !== {8'(k), 8'(k)}) begin bad++; $display("FAIL pp_drain%0d got=%h want=%h", k, bus.out_vec, {8'(k), 8'(k)}); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(8'd7, 8'd7, 4'd1);
    send(8'd8, 8'd8, 4'd1);
    send(8'd1, 8'd1, 4'd4);
    send(8'd1, 8'd1, 4'd4);
    total++; if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd2) begin bad++; $display("FAIL mid_setup got=%0b/%0d want=1/2", bus.busy, bus.fifo_count); end
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_vec !== 16'h0000) begin bad++; $display("FAIL mid_reset got=%0b/%0d/%0b/%h want=0/0/0/0000", bus.busy, bus.fifo_count, bus.out_valid, bus.out_vec); end
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    send(8'd1, 8'd2, 4'd4);
    send(8'd3, 8'd4, 4'd4);
    send(8'd5, 8'd6, 4'd4);
    send(8'd7, 8'd8, 4'd4);
    tick();
    total++; if (bus.out_vec !== 16'h1410 || bus.fifo_count !== 3'd1) begin bad++; $display("FAIL mid_clean got=%h/%0d want=1410/1", bus.out_vec, bus.fifo_count); end
    tick();
  endtask

  task automatic test_clear_beat();
    bus.out_ready = 1'b0;
    send(8'd9, 8'd9, 4'd1);
    send(8'd1, 8'd1, 4'd2);
    total++; if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd1) begin bad++; $display("FAIL clr_setup got=%0b/%0d want=1/1", bus.busy, bus.fifo_count); end
    bus.out_ready = 1'b1;
    bus.clear = 1'b1;
    send(8'd50, 8'd50, 4'd2);
    bus.clear = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_flush got=%0b/%0d/%0b want=0/0/0", bus.busy, bus.fifo_count, bus.out_valid); end
    send(8'd3, 8'd3, 4'd1);
    tick();
    total++; if (bus.out_vec !== 16'h0303 || bus.fifo_count !== 3'd1) begin bad++; $display("FAIL clr_after got=%h/%0d want=0303/1", bus.out_vec, bus.fifo_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tiles();
    test_wrap();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_clear_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
